// File: rtl/amo_sequencer.sv
// RV32A/RV64A atomic sequencer: runs AMO read-modify-write, LR and SC on a req/gnt
// memory port and owns the single LR/SC reservation (with store-snoop invalidation).
module amo_sequencer #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 32,
  parameter int RSV_GRAN = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [4:0]        i_req_funct5,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [XLEN-1:0]   i_req_data,
  output logic              o_resp_valid,
  output logic [XLEN-1:0]   o_resp_data,
  output logic              o_resp_err,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [XLEN-1:0]   o_mem_wdata,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [XLEN-1:0]   i_mem_rdata,
  input  logic              i_snoop_valid,
  input  logic [ADDR_W-1:0] i_snoop_addr
);

  localparam int OFF_W  = (XLEN == 64) ? 3 : 2;
  localparam int GRAN_W = ADDR_W - RSV_GRAN;

  localparam logic [4:0] F_ADD  = 5'b00000;
  localparam logic [4:0] F_SWAP = 5'b00001;
  localparam logic [4:0] F_LR   = 5'b00010;
  localparam logic [4:0] F_SC   = 5'b00011;
  localparam logic [4:0] F_XOR  = 5'b00100;
  localparam logic [4:0] F_OR   = 5'b01000;
  localparam logic [4:0] F_AND  = 5'b01100;
  localparam logic [4:0] F_MIN  = 5'b10000;
  localparam logic [4:0] F_MAX  = 5'b10100;
  localparam logic [4:0] F_MINU = 5'b11000;
  localparam logic [4:0] F_MAXU = 5'b11100;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_RWAIT = 3'd2,
    S_WR    = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  function automatic logic f_legal(input logic [4:0] f);
    case (f)
      F_ADD, F_SWAP, F_LR, F_SC, F_XOR, F_OR, F_AND,
      F_MIN, F_MAX, F_MINU, F_MAXU: f_legal = 1'b1;
      default:                      f_legal = 1'b0;
    endcase
  endfunction

  // Ties keep old: the compares are strict in the direction that would replace it.
  function automatic logic [XLEN-1:0] f_amo(input logic [4:0]      op,
                                            input logic [XLEN-1:0] old,
                                            input logic [XLEN-1:0] rs2);
    logic lt_s;
    logic gt_s;
    logic lt_u;
    logic gt_u;
    lt_s = $signed(rs2) < $signed(old);
    gt_s = $signed(rs2) > $signed(old);
    lt_u = rs2 < old;
    gt_u = rs2 > old;
    case (op)
      F_ADD:   f_amo = old + rs2;
      F_SWAP:  f_amo = rs2;
      F_XOR:   f_amo = old ^ rs2;
      F_OR:    f_amo = old | rs2;
      F_AND:   f_amo = old & rs2;
      F_MIN:   f_amo = lt_s ? rs2 : old;
      F_MAX:   f_amo = gt_s ? rs2 : old;
      F_MINU:  f_amo = lt_u ? rs2 : old;
      F_MAXU:  f_amo = gt_u ? rs2 : old;
      default: f_amo = old;
    endcase
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic [4:0]          r_op;
  logic [GRAN_W-1:0]   r_gran;
  logic [XLEN-1:0]     r_rs2;
  logic [XLEN-1:0]     r_old;
  logic                r_rsv_valid;
  logic [GRAN_W-1:0]   r_rsv_gran;
  logic                r_req_ready;
  logic                r_resp_valid;
  logic [XLEN-1:0]     r_resp_data;
  logic                r_resp_err;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [XLEN-1:0]     r_mem_wdata;

  logic                w_accept;
  logic                w_misalign;
  logic [ADDR_W-1:0]   w_req_word;
  logic [GRAN_W-1:0]   w_req_gran;
  logic [GRAN_W-1:0]   w_snp_gran;
  logic                w_snoop_rsv_hit;
  logic                w_sc_ok;
  logic                w_snoop_kill;
  logic                w_unused_snoop_low;
  logic [ADDR_W-1:0]   w_mem_addr_nxt;
  logic [XLEN-1:0]     w_mem_wdata_nxt;
  logic [XLEN-1:0]     w_resp_data_nxt;
  logic                w_resp_err_nxt;
  logic [XLEN-1:0]     w_old_nxt;
  logic                w_rsv_valid_pre;
  logic                w_rsv_valid_nxt;
  logic [GRAN_W-1:0]   w_rsv_gran_nxt;

  assign w_accept           = (r_state == S_IDLE) && i_req_valid;
  assign w_misalign         = |i_req_addr[OFF_W-1:0];
  assign w_req_word         = {i_req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign w_req_gran         = i_req_addr[ADDR_W-1:RSV_GRAN];
  assign w_snp_gran         = i_snoop_addr[ADDR_W-1:RSV_GRAN];
  assign w_unused_snoop_low = ^i_snoop_addr[RSV_GRAN-1:0];
  assign w_snoop_rsv_hit    = i_snoop_valid && r_rsv_valid && (w_snp_gran == r_rsv_gran);
  assign w_sc_ok            = r_rsv_valid && (w_req_gran == r_rsv_gran) && !w_snoop_rsv_hit;

  // Next-state, next-output and reservation update for the sequencing FSM.
  always_comb begin
    w_state_nxt     = r_state;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_resp_data_nxt = {XLEN{1'b0}};
    w_resp_err_nxt  = 1'b0;
    w_old_nxt       = r_old;
    w_rsv_valid_pre = r_rsv_valid;
    w_rsv_gran_nxt  = r_rsv_gran;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid) begin
          if (!f_legal(i_req_funct5) || w_misalign) begin
            w_state_nxt    = S_RESP;
            w_resp_err_nxt = 1'b1;
          end else if (i_req_funct5 == F_SC) begin
            w_rsv_valid_pre = 1'b0;
            if (w_sc_ok) begin
              w_state_nxt     = S_WR;
              w_mem_addr_nxt  = w_req_word;
              w_mem_wdata_nxt = i_req_data;
            end else begin
              w_state_nxt     = S_RESP;
              w_resp_data_nxt = {{(XLEN-1){1'b0}}, 1'b1};
            end
          end else begin
            w_state_nxt    = S_RD;
            w_mem_addr_nxt = w_req_word;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RD: begin
        if (i_mem_gnt) begin
          w_state_nxt = S_RWAIT;
        end else begin
          w_state_nxt = S_RD;
        end
      end
      S_RWAIT: begin
        if (i_mem_rvalid) begin
          w_old_nxt = i_mem_rdata;
          if (r_op == F_LR) begin
            w_state_nxt     = S_RESP;
            w_resp_data_nxt = i_mem_rdata;
            w_rsv_valid_pre = 1'b1;
            w_rsv_gran_nxt  = r_gran;
          end else begin
            w_state_nxt     = S_WR;
            w_mem_wdata_nxt = f_amo(r_op, i_mem_rdata, r_rs2);
          end
        end else begin
          w_state_nxt = S_RWAIT;
        end
      end
      S_WR: begin
        if (i_mem_gnt) begin
          w_state_nxt = S_RESP;
          if (r_op == F_SC) begin
            w_resp_data_nxt = {XLEN{1'b0}};
          end else begin
            w_resp_data_nxt = r_old;
            if (r_rsv_valid && (r_gran == r_rsv_gran)) begin
              w_rsv_valid_pre = 1'b0;
            end else begin
              w_rsv_valid_pre = r_rsv_valid;
            end
          end
        end else begin
          w_state_nxt = S_WR;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A snoop on the granule being held or being set by LR always wins.
  assign w_snoop_kill    = i_snoop_valid && (w_snp_gran == w_rsv_gran_nxt);
  assign w_rsv_valid_nxt = w_rsv_valid_pre && !w_snoop_kill;

  // State, registered outputs, latched request and reservation.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_op         <= 5'b00000;
      r_gran       <= {GRAN_W{1'b0}};
      r_rs2        <= {XLEN{1'b0}};
      r_old        <= {XLEN{1'b0}};
      r_rsv_valid  <= 1'b0;
      r_rsv_gran   <= {GRAN_W{1'b0}};
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_data  <= {XLEN{1'b0}};
      r_resp_err   <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= {ADDR_W{1'b0}};
      r_mem_wdata  <= {XLEN{1'b0}};
    end else begin
      r_state      <= w_state_nxt;
      r_old        <= w_old_nxt;
      r_rsv_valid  <= w_rsv_valid_nxt;
      r_rsv_gran   <= w_rsv_gran_nxt;
      r_req_ready  <= (w_state_nxt == S_IDLE);
      r_resp_valid <= (w_state_nxt == S_RESP);
      r_resp_data  <= w_resp_data_nxt;
      r_resp_err   <= w_resp_err_nxt;
      r_mem_req    <= (w_state_nxt == S_RD) || (w_state_nxt == S_WR);
      r_mem_we     <= (w_state_nxt == S_WR);
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      if (w_accept) begin
        r_op   <= i_req_funct5;
        r_gran <= w_req_gran;
        r_rs2  <= i_req_data;
      end
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_data  = r_resp_data;
  assign o_resp_err   = r_resp_err;
  assign o_mem_req    = r_mem_req;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;

endmodule
